// File: rtl/ddr_bw_pkg.sv
// Shared types and helpers for the DDR read-bandwidth checker.
package ddr_bw_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam int LANE_BITS          = 32;
    localparam int DATA_WIDTH_DEFAULT = 64;
    localparam int LANES              = DATA_WIDTH_DEFAULT / LANE_BITS;

    // Number of 32-bit pattern lanes carried by one beat.
    function automatic int lanes(input int data_width);
        return data_width / LANE_BITS;
    endfunction

    // BURST_LENGTH is encoded as beats-minus-one, like the read master.
    function automatic logic [31:0] beats_per_burst(input int burst_length);
        return 32'(burst_length + 1);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/bw_pattern_gen.sv
// Expected-data generator: one incrementing 32-bit counter per lane.
module bw_pattern_gen
    import ddr_bw_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic                  advance,
    input  logic [31:0]           seed,
    output logic [DATA_WIDTH-1:0] expected
);

    localparam int NLANES = lanes(DATA_WIDTH);

    // Lane k starts at seed+k; every accepted beat moves all lanes by NLANES.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            expected <= '0;
        end else if (load) begin
            for (int k = 0; k < NLANES; k++) begin
                expected[k*32 +: 32] <= seed + 32'(k);
            end
        end else if (advance) begin
            for (int k = 0; k < NLANES; k++) begin
                expected[k*32 +: 32] <= expected[k*32 +: 32] + 32'(NLANES);
            end
        end
    end

endmodule

// File: rtl/axis_bw_checker.sv
// AXIS sink that counts, times and pattern-checks beats from the DDR read master.
module axis_bw_checker
    import ddr_bw_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
    parameter int BURST_LENGTH = 7,
    parameter int TIMEOUT      = 4096
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    input  logic                    START_REG,
    input  logic [31:0]             NBURST_REG,
    input  logic [31:0]             SEED_REG,
    input  logic [7:0]              THROTTLE_REG,
    output logic                    BUSY_REG,
    output logic                    DONE_REG,
    output logic                    TIMEOUT_REG,
    output logic [31:0]             BEAT_CNT_REG,
    output logic [31:0]             CYCLE_CNT_REG,
    output logic [31:0]             ERR_CNT_REG,
    output logic [31:0]             EXTRA_CNT_REG,
    output logic [31:0]             FIRST_ERR_IDX_REG,
    output logic [DATA_WIDTH-1:0]   FIRST_ERR_DATA_REG
);

    state_t                 state;
    logic [31:0]            target_q;
    logic [7:0]             throttle_q;
    logic [7:0]             thr_cnt;
    logic [31:0]            idle_cnt;
    logic                   accept;
    logic                   thr_gap;
    logic [31:0]            target_next;
    logic [DATA_WIDTH-1:0]  exp_data;
    logic                   cmp_valid;
    logic [DATA_WIDTH-1:0]  cmp_data;
    logic [DATA_WIDTH-1:0]  cmp_exp;
    logic [31:0]            cmp_idx;
    logic                   unused_inputs;

    // Strobes and tlast carry no information for a fixed-length pattern run.
    assign unused_inputs = ^{s_axis_tstrb, s_axis_tlast};

    assign target_next = NBURST_REG * beats_per_burst(BURST_LENGTH);
    assign thr_gap     = (throttle_q != 8'd0) && (thr_cnt == throttle_q);
    assign accept      = s_axis_tvalid && s_axis_tready;
    assign BUSY_REG    = (state == S_ARM) || (state == S_RUN) || (state == S_FLUSH);
    assign DONE_REG    = (state == S_DONE);

    // Ready: throttled in RUN, always open in DONE so upstream drains, closed otherwise.
    always_comb begin
        // NOTE: default assignment first so no path leaves the output unassigned (no latch).
        s_axis_tready = 1'b0;
        case (state)
            S_RUN:   s_axis_tready = !thr_gap;
            S_DONE:  s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
        endcase
    end

    bw_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pattern (
        .clk      (clk),
        .rstn     (rstn),
        .load     (state == S_ARM),
        .advance  (accept && (state == S_RUN)),
        .seed     (SEED_REG),
        .expected (exp_data)
    );

    // First compare stage: capture the accepted beat alongside its expected value.
    // NOTE: pure datapath registers qualified by cmp_valid need no reset.
    always_ff @(posedge clk) begin
        if (accept && (state == S_RUN)) begin
            cmp_data <= s_axis_tdata;
            cmp_exp  <= exp_data;
            cmp_idx  <= BEAT_CNT_REG;
        end
    end

    // Run control FSM, counters and second compare stage.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
        if (!rstn) begin
            state              <= S_IDLE;
            target_q           <= '0;
            throttle_q         <= '0;
            thr_cnt            <= '0;
            idle_cnt           <= '0;
            cmp_valid          <= 1'b0;
            TIMEOUT_REG        <= 1'b0;
            BEAT_CNT_REG       <= '0;
            CYCLE_CNT_REG      <= '0;
            ERR_CNT_REG        <= '0;
            EXTRA_CNT_REG      <= '0;
            FIRST_ERR_IDX_REG  <= '1;
            FIRST_ERR_DATA_REG <= '0;
        end else begin
            cmp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START_REG) state <= S_ARM;
                end
                S_ARM: begin
                    target_q           <= target_next;
                    throttle_q         <= THROTTLE_REG;
                    thr_cnt            <= '0;
                    idle_cnt           <= '0;
                    TIMEOUT_REG        <= 1'b0;
                    BEAT_CNT_REG       <= '0;
                    CYCLE_CNT_REG      <= '0;
                    ERR_CNT_REG        <= '0;
                    EXTRA_CNT_REG      <= '0;
                    FIRST_ERR_IDX_REG  <= '1;
                    FIRST_ERR_DATA_REG <= '0;
                    state              <= (target_next == 32'd0) ? S_FLUSH : S_RUN;
                end
                S_RUN: begin
                    CYCLE_CNT_REG <= sat_inc(CYCLE_CNT_REG);
                    thr_cnt       <= (thr_cnt == throttle_q) ? 8'd0 : thr_cnt + 8'd1;
                    if (accept) begin
                        BEAT_CNT_REG <= BEAT_CNT_REG + 32'd1;
                        idle_cnt     <= '0;
                        cmp_valid    <= 1'b1;
                        if (BEAT_CNT_REG + 32'd1 == target_q) state <= S_FLUSH;
                    end else if (idle_cnt == 32'(TIMEOUT - 1)) begin
                        TIMEOUT_REG <= 1'b1;
                        state       <= S_FLUSH;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                S_FLUSH: begin
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (accept) EXTRA_CNT_REG <= sat_inc(EXTRA_CNT_REG);
                    if (!START_REG) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (cmp_valid && (cmp_data != cmp_exp)) begin
                ERR_CNT_REG <= sat_inc(ERR_CNT_REG);
                if (ERR_CNT_REG == 32'd0) begin
                    FIRST_ERR_IDX_REG  <= cmp_idx;
                    FIRST_ERR_DATA_REG <= cmp_data;
                end
            end
        end
    end

endmodule

// File: doc/axis_bw_checker.md
Name: axis_bw_checker

Overview:
- AXIS sink directly downstream of the DDR read master, on the master's m_axis_* output.
- Consumes the beats the read master produces and counts them.
- Checks each beat against a deterministic 32-bit incrementing pattern.
- Measures elapsed cycles and exposes results as registers so software can compute DDR read bandwidth and data integrity.

Parameters:
- DATA_WIDTH, 64, AXIS data width; must be a multiple of 32.
- BURST_LENGTH, 7, beats per burst minus 1; must match the read master.
- TIMEOUT, 4096, idle cycles without an accepted beat in RUN before aborting.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- s_axis_tvalid  in  1  stream valid
- s_axis_tdata  in  DATA_WIDTH  stream data
- s_axis_tstrb  in  DATA_WIDTH/8  ignored
- s_axis_tlast  in  1  ignored
- s_axis_tready  out  1  stream ready
- START_REG  in  1  level start; same handshake as the read master
- NBURST_REG  in  32  number of bursts expected
- SEED_REG  in  32  pattern seed
- THROTTLE_REG  in  8  0 = ready always; N>0 = ready low 1 cycle in every N+1
- BUSY_REG  out  1  high in ARM/RUN/FLUSH
- DONE_REG  out  1  high in DONE
- TIMEOUT_REG  out  1  run ended by timeout
- BEAT_CNT_REG  out  32  beats accepted
- CYCLE_CNT_REG  out  32  run cycles
- ERR_CNT_REG  out  32  mismatching beats
- EXTRA_CNT_REG  out  32  beats accepted in DONE
- FIRST_ERR_IDX_REG  out  32  index of first bad beat
- FIRST_ERR_DATA_REG  out  DATA_WIDTH  data of first bad beat

Behaviour:
- Reset: state IDLE.
  - tready = 0.
  - All counters, flags and FIRST_ERR_* are 0.
  - FIRST_ERR_IDX_REG = 0xFFFFFFFF.
- States: IDLE, ARM, RUN, FLUSH, DONE.
- IDLE -> ARM when START_REG = 1.
- ARM (1 cycle):
  - Latches NBURST, SEED, THROTTLE.
  - Computes target = NBURST * (BURST_LENGTH + 1) as a 32-bit product that wraps.
  - Clears all counters/flags.
  - Sets FIRST_ERR_IDX to 0xFFFFFFFF.
  - Goes to RUN, or to FLUSH if target = 0.
- RUN:
  - tready follows the throttle pattern; the throttle counter restarts at ARM.
  - Accept = tvalid & tready.
  - CYCLE_CNT increments every RUN cycle, including the cycle of the last accept, and saturates.
- Expected data for beat i: 32-bit lane k = SEED + i * (DATA_WIDTH/32) + k, mod 2^32.
- Compare pipeline:
  - Beat accepted at cycle t: BEAT_CNT updates at t+1.
  - Data and expected data are registered at t+1.
  - ERR_CNT updates at t+2 and saturates.
  - On the first mismatch only, FIRST_ERR_IDX and FIRST_ERR_DATA are captured at t+2.
- RUN -> FLUSH on the accept where BEAT_CNT + 1 = target.
- RUN -> FLUSH when an idle counter reaches TIMEOUT; TIMEOUT_REG set.
  - The idle counter resets on each accept and also counts cycles stalled by throttle.
- FLUSH: tready = 0; waits 1 cycle for the compare pipe to drain, then DONE.
  - DONE_REG is high 2 cycles after the last accept.
- DONE:
  - tready = 1 so upstream never hangs.
  - Extra beats increment EXTRA_CNT (saturating) and are not checked.
  - DONE -> IDLE when START_REG = 0.
  - Results hold until the next ARM.
- START_REG dropping during RUN is ignored; the run completes or times out.
- rstn low at any time returns to the reset state next clock edge. The upstream FIFO is not flushed by this block.

Decomposition:
- Package ddr_bw_pkg holds:
  - The state enum.
  - Constant LANES = DATA_WIDTH/32.
  - Function beats_per_burst(BURST_LENGTH).
- Sub-module bw_pattern_gen holds the expected-data generator:
  - Loads SEED on ARM.
  - Outputs the expected beat for the current index.
  - Advances all lanes by LANES on accept.

Test Plan:
1. NBURST=4, SEED=0x100, THROTTLE=0, correct pattern with tvalid held high -> BEAT_CNT=32, ERR_CNT=0, CYCLE_CNT=32, DONE 2 cycles after the 32nd accept, FIRST_ERR_IDX=0xFFFFFFFF.
2. Same run with beat 5 lane 1 corrupted to 0xDEADBEEF -> ERR_CNT=1, FIRST_ERR_IDX=5, FIRST_ERR_DATA equals the corrupted beat.
3. THROTTLE=3, NBURST=2 -> tready low every 4th cycle, BEAT_CNT=16, CYCLE_CNT=21, ERR_CNT=0.
4. NBURST=2, source stops after 10 beats -> TIMEOUT_REG=1, BEAT_CNT=10, DONE after TIMEOUT idle cycles; 3 extra beats sent in DONE -> EXTRA_CNT=3.
5. NBURST=0 -> DONE within 3 cycles of START, all counts 0. SEED=0xFFFFFFFE -> lanes wrap to 0x00000000, no errors.
6. rstn low mid-RUN with START held high -> all outputs at reset values, then a fresh run starts from ARM.
